// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the gpio AXI4-Lite arbiter.
// Holds the FSM state encoding, AXI response codes and fixed channel attributes.
package gpio_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RA,
    ST_RD,
    ST_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [3:0] WSTRB_ALL    = 4'hF;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Two-way round-robin grant: a lone requester always wins, and on contention
// the requester that did not win last time is chosen.
module gpio_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

endmodule

// File: rtl/gpio_axil_arbiter.sv
// Shares the gpio AXI4-Lite slave port between two single-beat requesters,
// sequencing AW/W/B or AR/R and returning a one-cycle response pulse.
//
// state   | meaning
// IDLE    | arbitrate, accept one request
// WR      | AW and W valids, each dropped after its own handshake
// WB      | wait for write response
// RA      | read address phase
// RD      | wait for read data
// RSP     | one-cycle rsp_valid pulse, update counter and error flag
module gpio_axil_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  output logic [CNT_WIDTH-1:0]    txn_cnt,
  output logic                    err_sticky
);

  // Word-aligned register space: byte-lane bits are forced to zero.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  state_t                  state, state_nxt;
  logic                    last_grant;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;
  logic                    aw_done, w_done;
  logic [1:0]              grant;
  logic                    accept, sel;
  logic                    aw_hs, w_hs;

  gpio_rr_arbiter u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (state == ST_IDLE),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel       = grant[1];

  assign M_AXI_AWVALID = (state == ST_WR) && !aw_done;
  assign M_AXI_WVALID  = (state == ST_WR) && !w_done;
  assign M_AXI_BREADY  = (state == ST_WB);
  assign M_AXI_ARVALID = (state == ST_RA);
  assign M_AXI_RREADY  = (state == ST_RD);
  assign M_AXI_AWADDR  = addr_q & ADDR_MASK;
  assign M_AXI_ARADDR  = addr_q & ADDR_MASK;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = WSTRB_ALL;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_ARPROT  = PROT_DEFAULT;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

  always_comb begin
    state_nxt = state;
    rsp_valid = 2'b00;
    rsp_rdata = '0;
    rsp_resp  = RESP_OKAY;
    case (state)
      ST_IDLE: if (accept) state_nxt = req_write[sel] ? ST_WR : ST_RA;
      ST_WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WB;
      ST_WB:   if (M_AXI_BVALID) state_nxt = ST_RSP;
      ST_RA:   if (M_AXI_ARREADY) state_nxt = ST_RD;
      ST_RD:   if (M_AXI_RVALID) state_nxt = ST_RSP;
      ST_RSP: begin
        rsp_valid[last_grant] = 1'b1;
        rsp_rdata             = rdata_q;
        rsp_resp              = resp_q;
        state_nxt             = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= RESP_OKAY;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      txn_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (accept) begin
          last_grant <= sel;
          addr_q     <= sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          wdata_q    <= sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          aw_done    <= 1'b0;
          w_done     <= 1'b0;
        end
        ST_WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        ST_WB: if (M_AXI_BVALID) begin
          resp_q  <= M_AXI_BRESP;
          rdata_q <= '0;
        end
        ST_RD: if (M_AXI_RVALID) begin
          resp_q  <= M_AXI_RRESP;
          rdata_q <= M_AXI_RDATA;
        end
        ST_RSP: begin
          if (txn_cnt != {CNT_WIDTH{1'b1}}) txn_cnt <= txn_cnt + CNT_WIDTH'(1);
          if (resp_is_err(resp_q)) err_sticky <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_axil_arbiter.sv
// Directed bench for gpio_axil_arbiter: scoreboard of expected responses,
// monitor popping on each rsp_valid pulse, and a small AXI4-Lite slave model.
module tb_gpio_axil_arbiter;

  localparam int AW = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  req_valid, req_write;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready, rsp_valid, rsp_resp;
  logic [31:0] rsp_rdata;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [15:0] txn_cnt;
  logic        err_sticky;

  always #5 ACLK = ~ACLK;

  gpio_axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .txn_cnt(txn_cnt), .err_sticky(err_sticky)
  );

  // Slave model: AWREADY after aw_lat stall cycles, WREADY/ARREADY immediate,
  // B one cycle after both write handshakes, R one cycle after AR unless held.
  int          aw_lat = 0;
  logic        r_hold = 1'b0;
  logic [1:0]  bresp_val = 2'b00;
  int          aw_cnt;
  logic        got_aw, got_w, rpend;
  logic [3:0]  aw_q, ar_q;
  logic [31:0] w_q;
  logic [31:0] mem [4];

  assign awready = awvalid && (aw_cnt >= aw_lat);
  assign wready  = wvalid;
  assign bvalid  = got_aw && got_w;
  assign bresp   = bresp_val;
  assign arready = arvalid;
  assign rvalid  = rpend && !r_hold;
  assign rdata   = mem[ar_q[3:2]];
  assign rresp   = 2'b00;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; rpend <= 1'b0;
      aw_q <= '0; ar_q <= '0; w_q <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      if (awvalid && awready) begin got_aw <= 1'b1; aw_q <= awaddr; end
      if (wvalid && wready)   begin got_w  <= 1'b1; w_q  <= wdata;  end
      if (bvalid && bready) begin
        mem[aw_q[3:2]] <= w_q;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end
      if (arvalid && arready) begin rpend <= 1'b1; ar_q <= araddr; end
      if (rvalid && rready) rpend <= 1'b0;
    end
  end

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] rd, input logic [1:0] rs);
    exp_t e;
    e.id = id; e.rdata = rd; e.resp = rs;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int i, input logic w, input logic [3:0] a, input logic [31:0] d);
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*32 +: 32] = d;
    req_valid[i]          = 1'b1;
  endtask

  // Waits for any grant, checks it is requester i, then drops i's valid after the edge.
  task automatic wait_accept(input int i);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge ACLK);
      if (req_ready != 2'b00) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL grant_timeout actual=none expected=req%0d", i);
      req_valid[i] = 1'b0;
    end else begin
      chk("grant", {30'd0, req_ready}, (i == 1) ? 32'd2 : 32'd1);
      @(posedge ACLK); #1;
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge ACLK);
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_q.size());
      exp_q.delete();
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    ARESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge ACLK);
          if (!ARESET && rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL rsp_unexpected actual=%b expected=none", rsp_valid);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_valid", {30'd0, rsp_valid}, (e.id == 1) ? 32'd2 : 32'd1);
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awvalid", {31'd0, awvalid}, 0);
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_rready",  {31'd0, rready}, 0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
    chk("rst_txn_cnt", {16'd0, txn_cnt}, 0);
    chk("rst_err", {31'd0, err_sticky}, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Write, zero-wait slave: cycle-by-cycle latency
    @(posedge ACLK); #1;
    push(0, 32'h0, 2'b00);
    issue(0, 1'b1, 4'h4, 32'hA5A5_0001);
    wait_accept(0);
    @(negedge ACLK);
    chk("wr_awvalid_c1", {31'd0, awvalid}, 1);
    chk("wr_wvalid_c1",  {31'd0, wvalid}, 1);
    chk("wr_awaddr",     {28'd0, awaddr}, 32'h4);
    chk("wr_wdata",      wdata, 32'hA5A5_0001);
    chk("wr_wstrb",      {28'd0, wstrb}, 32'hF);
    chk("wr_awprot",     {29'd0, awprot}, 0);
    @(negedge ACLK);
    chk("wr_bready_c2",  {31'd0, bready}, 1);
    @(negedge ACLK);
    chk("wr_rsp_c3",     {30'd0, rsp_valid}, 1);
    @(negedge ACLK);
    chk("wr_txn_cnt",    {16'd0, txn_cnt}, 1);
    @(posedge ACLK); #1;

    // Read-back from requester 1 with unaligned address
    push(1, 32'hA5A5_0001, 2'b00);
    issue(1, 1'b0, 4'h7, 32'h0);
    wait_accept(1);
    @(negedge ACLK);
    chk("rd_arvalid", {31'd0, arvalid}, 1);
    chk("rd_araddr",  {28'd0, araddr}, 32'h4);
    drain();
    chk("rd_txn_cnt", {16'd0, txn_cnt}, 2);

    // Contention: both held valid, grants alternate 0,1,0,1
    push(0, 32'h0, 2'b00);
    push(1, 32'h1111_0000, 2'b00);
    push(0, 32'h0, 2'b00);
    push(1, 32'h0000_2222, 2'b00);
    issue(0, 1'b1, 4'h8, 32'h1111_0000);
    issue(1, 1'b0, 4'h8, 32'h0);
    wait_accept(0);
    issue(0, 1'b1, 4'hC, 32'h0000_2222);
    wait_accept(1);
    issue(1, 1'b0, 4'hC, 32'h0);
    wait_accept(0);
    wait_accept(1);
    drain();
    chk("cont_txn_cnt", {16'd0, txn_cnt}, 6);
    chk("cont_err", {31'd0, err_sticky}, 0);

    // Skewed handshake: AWREADY stalls 3 cycles, WREADY immediate
    aw_lat = 3;
    push(0, 32'h0, 2'b00);
    issue(0, 1'b1, 4'h0, 32'hDEAD_0000);
    wait_accept(0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge ACLK);
      chk($sformatf("skew_awvalid_c%0d", c), {31'd0, awvalid}, (c <= 4) ? 1 : 0);
      chk($sformatf("skew_wvalid_c%0d", c),  {31'd0, wvalid},  (c == 1) ? 1 : 0);
      chk($sformatf("skew_bready_c%0d", c),  {31'd0, bready},  (c == 5) ? 1 : 0);
    end
    drain();
    aw_lat = 0;

    // Error response sets the sticky flag; later OKAY leaves it set
    bresp_val = 2'b10;
    push(1, 32'h0, 2'b10);
    issue(1, 1'b1, 4'h4, 32'h0000_0005);
    wait_accept(1);
    drain();
    chk("err_set", {31'd0, err_sticky}, 1);
    bresp_val = 2'b00;
    push(0, 32'h0000_0005, 2'b00);
    issue(0, 1'b0, 4'h4, 32'h0);
    wait_accept(0);
    drain();
    chk("err_kept", {31'd0, err_sticky}, 1);
    chk("err_txn_cnt", {16'd0, txn_cnt}, 9);

    // Reset while waiting for read data
    r_hold = 1'b1;
    issue(0, 1'b0, 4'h0, 32'h0);
    wait_accept(0);
    @(negedge ACLK);
    chk("mid_arvalid", {31'd0, arvalid}, 1);
    @(negedge ACLK);
    chk("mid_rready", {31'd0, rready}, 1);
    #1 ARESET = 1'b1;
    #1;
    chk("mid_rready_rst",  {31'd0, rready}, 0);
    chk("mid_arvalid_rst", {31'd0, arvalid}, 0);
    chk("mid_rsp_rst",     {30'd0, rsp_valid}, 0);
    chk("mid_txn_cnt",     {16'd0, txn_cnt}, 0);
    chk("mid_err",         {31'd0, err_sticky}, 0);
    r_hold = 1'b0;
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // First contention after reset goes to requester 0
    push(0, 32'h0, 2'b00);
    push(1, 32'h0000_0077, 2'b00);
    issue(0, 1'b1, 4'h0, 32'h0000_0077);
    issue(1, 1'b0, 4'h0, 32'h0);
    wait_accept(0);
    wait_accept(1);
    drain();
    chk("post_rst_txn_cnt", {16'd0, txn_cnt}, 2);

    repeat (3) @(posedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
